// File: rtl/dlx_pipe_pkg.sv
// Shared types and stage indices for the DLX in-order pipeline control slice.
package dlx_pipe_pkg;

  typedef enum logic [0:0] {
    MC_IDLE,
    MC_BUSY
  } mc_state_t;

  localparam int unsigned IF_S  = 0;
  localparam int unsigned ID_S  = 1;
  localparam int unsigned EX_S  = 2;
  localparam int unsigned MEM_S = 3;
  localparam int unsigned WB_S  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 16
);

  logic                  fetch_valid;
  logic                  ld_use_hazard;
  logic                  ex_multicycle;
  logic                  ex_redirect;
  logic                  pc_hold;
  logic [NUM_STAGES-2:0] stage_hold;
  logic [NUM_STAGES-2:0] stage_bubble;
  logic [NUM_STAGES-2:0] stage_valid;
  logic                  mul_busy;
  logic                  mul_done;
  logic                  retire;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output fetch_valid, ld_use_hazard, ex_multicycle, ex_redirect,
    input  pc_hold, stage_hold, stage_bubble, stage_valid, mul_busy, mul_done, retire,
           stall_cycles
  );

  modport slave (
    input  fetch_valid, ld_use_hazard, ex_multicycle, ex_redirect,
    output pc_hold, stage_hold, stage_bubble, stage_valid, mul_busy, mul_done, retire,
           stall_cycles
  );

endinterface

// File: rtl/pipe_mc_tracker.sv
// Multicycle EX occupancy tracker: busy for MUL_LATENCY-1 cycles, then a one-cycle done pulse.
module pipe_mc_tracker
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ex_mc,
  output logic mul_busy,
  output logic mul_done
);

  localparam int unsigned CntW    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_LATENCY - 1);
  localparam bit Multi = (MUL_LATENCY > 1);

  mc_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MC_IDLE: begin
        if (ex_mc && Multi) begin
          state_d = MC_BUSY;
          cnt_d   = CntW'(1);
        end
      end
      MC_BUSY: begin
        if (cnt_q == LastCnt) begin
          state_d = MC_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  // Single-cycle ops report done in their only EX cycle and never stall.
  always_comb begin
    mul_busy = 1'b0;
    mul_done = 1'b0;
    if (!reset) begin
      unique case (state_q)
        MC_IDLE: begin
          if (ex_mc) begin
            if (Multi) mul_busy = 1'b1;
            else       mul_done = 1'b1;
          end
        end
        MC_BUSY: begin
          if (cnt_q == LastCnt) mul_done = 1'b1;
          else                  mul_busy = 1'b1;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  localparam logic [CntW:0] MaxRun = (CntW + 1)'(MUL_LATENCY - 1);
  logic [CntW:0] busy_run_q;

  always_ff @(posedge clock) begin
    if (reset || !mul_busy) busy_run_q <= '0;
    else                    busy_run_q <= busy_run_q + (CntW + 1)'(1);
  end

  a_busy_bounded: assert property (@(posedge clock) disable iff (reset)
    mul_busy |-> (busy_run_q < MaxRun));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/valid controller: per-pipe-register hold and bubble strobes, PC hold,
// valid tracking, retirement and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = WB_S + 1,
  parameter int unsigned EX_STAGE    = EX_S,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input logic clock,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned NR = NUM_STAGES - 1;
  localparam logic [NR-1:0] OneReg    = NR'(1);
  localparam logic [NR-1:0] ExReg     = OneReg << EX_STAGE;
  localparam logic [NR-1:0] FrontRegs = ExReg - OneReg;
  localparam logic [NR-1:0] IdExReg   = OneReg << (EX_STAGE - 1);
  localparam logic [NR-1:0] PreIdRegs = IdExReg - OneReg;

  logic [NR-1:0]    valid_q, valid_d, shifted;
  logic [NR-1:0]    hold, bubble;
  logic             pc_hold;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             mc_req, redir, ld_use;
  logic             mul_busy, mul_done;

  assign mc_req = bus.ex_multicycle & valid_q[EX_STAGE-1];
  assign redir  = bus.ex_redirect & valid_q[EX_STAGE-1];
  assign ld_use = bus.ld_use_hazard & valid_q[0];

  pipe_mc_tracker #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mc_tracker (
    .clock   (clock),
    .reset   (reset),
    .ex_mc   (mc_req),
    .mul_busy(mul_busy),
    .mul_done(mul_done)
  );

  // Multicycle stall freezes only the front end; registers past EX keep draining.
  always_comb begin
    pc_hold = 1'b0;
    hold    = '0;
    bubble  = '0;
    if (reset) begin
      bubble = '1;
    end else if (mul_busy) begin
      pc_hold = 1'b1;
      hold    = FrontRegs;
      bubble  = ExReg;
    end else if (redir) begin
      bubble = FrontRegs;
    end else if (ld_use) begin
      pc_hold = 1'b1;
      hold    = PreIdRegs;
      bubble  = IdExReg;
    end
  end

  always_comb begin
    shifted = {valid_q[NR-2:0], bus.fetch_valid};
    valid_d = ~bubble & ((hold & valid_q) | (~hold & shifted));
  end

  always_comb begin
    stall_d = stall_q;
    if (pc_hold && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_hold      = pc_hold;
  assign bus.stage_hold   = hold;
  assign bus.stage_bubble = bubble;
  assign bus.stage_valid  = valid_q;
  assign bus.mul_busy     = mul_busy;
  assign bus.mul_done     = mul_done;
  assign bus.retire       = valid_q[NR-1];
  assign bus.stall_cycles = stall_q;

`ifndef SYNTHESIS
  a_hold_bubble_excl: assert property (@(posedge clock) (hold & bubble) == '0);
  a_no_redirect_mc: assert property (@(posedge clock) disable iff (reset)
    !(redir && mc_req));
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default config plus a CNT_W=3, MUL_LATENCY=10 instance.
module tb_pipe_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_bad;
  int   n;

  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_W(16)) a_if ();
  pipe_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_W(3))  b_if ();

  pipe_hazard_ctrl #(
    .NUM_STAGES (5),
    .EX_STAGE   (2),
    .MUL_LATENCY(4),
    .CNT_W      (16)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (a_if.slave)
  );

  pipe_hazard_ctrl #(
    .NUM_STAGES (5),
    .EX_STAGE   (2),
    .MUL_LATENCY(10),
    .CNT_W      (3)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (b_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_bad    = 0;
    reset    = 1'b1;
    a_if.fetch_valid = 1'b0; a_if.ld_use_hazard = 1'b0;
    a_if.ex_multicycle = 1'b0; a_if.ex_redirect = 1'b0;
    b_if.fetch_valid = 1'b0; b_if.ld_use_hazard = 1'b0;
    b_if.ex_multicycle = 1'b0; b_if.ex_redirect = 1'b0;
    tick();
    tick();
    #1;
    check("rst_pc_hold", 32'(a_if.pc_hold), 32'd0);
    check("rst_hold", 32'(a_if.stage_hold), 32'h0);
    check("rst_bubble", 32'(a_if.stage_bubble), 32'hf);
    check("rst_valid", 32'(a_if.stage_valid), 32'h0);
    check("rst_busy", 32'(a_if.mul_busy), 32'd0);
    check("rst_stall", 32'(a_if.stall_cycles), 32'd0);

    // Fill the pipe
    reset = 1'b0;
    a_if.fetch_valid = 1'b1;
    #1;
    check("run_bubble", 32'(a_if.stage_bubble), 32'h0);
    repeat (4) tick();
    check("fill_valid", 32'(a_if.stage_valid), 32'hf);
    check("fill_retire", 32'(a_if.retire), 32'd1);
    tick();
    check("fill_retire2", 32'(a_if.retire), 32'd1);
    check("fill_stall", 32'(a_if.stall_cycles), 32'd0);

    // Multicycle op in EX: 3 stall cycles then done
    a_if.ex_multicycle = 1'b1;
    #1;
    check("mc0_busy", 32'(a_if.mul_busy), 32'd1);
    check("mc0_pc_hold", 32'(a_if.pc_hold), 32'd1);
    check("mc0_hold", 32'(a_if.stage_hold), 32'h3);
    check("mc0_bubble", 32'(a_if.stage_bubble), 32'h4);
    tick();
    check("mc1_valid", 32'(a_if.stage_valid), 32'hb);
    check("mc1_busy", 32'(a_if.mul_busy), 32'd1);
    check("mc1_stall", 32'(a_if.stall_cycles), 32'd1);
    tick();
    check("mc2_valid", 32'(a_if.stage_valid), 32'h3);
    check("mc2_busy", 32'(a_if.mul_busy), 32'd1);
    tick();
    check("mc3_busy", 32'(a_if.mul_busy), 32'd0);
    check("mc3_done", 32'(a_if.mul_done), 32'd1);
    check("mc3_pc_hold", 32'(a_if.pc_hold), 32'd0);
    check("mc3_hold", 32'(a_if.stage_hold), 32'h0);
    check("mc3_stall", 32'(a_if.stall_cycles), 32'd3);
    tick();
    a_if.ex_multicycle = 1'b0;
    #1;
    check("mc4_valid", 32'(a_if.stage_valid), 32'h7);
    check("mc4_done", 32'(a_if.mul_done), 32'd0);
    check("mc4_stall", 32'(a_if.stall_cycles), 32'd3);

    // Load-use hazard for one cycle
    a_if.ld_use_hazard = 1'b1;
    #1;
    check("lu_pc_hold", 32'(a_if.pc_hold), 32'd1);
    check("lu_hold", 32'(a_if.stage_hold), 32'h1);
    check("lu_bubble", 32'(a_if.stage_bubble), 32'h2);
    tick();
    a_if.ld_use_hazard = 1'b0;
    #1;
    check("lu1_valid", 32'(a_if.stage_valid), 32'hd);
    check("lu1_stall", 32'(a_if.stall_cycles), 32'd4);
    check("lu1_pc_hold", 32'(a_if.pc_hold), 32'd0);
    check("lu1_bubble", 32'(a_if.stage_bubble), 32'h0);
    tick();
    check("lu2_valid", 32'(a_if.stage_valid), 32'hb);

    // Redirect overrides a simultaneous load-use
    a_if.ex_redirect = 1'b1;
    a_if.ld_use_hazard = 1'b1;
    #1;
    check("rd_bubble", 32'(a_if.stage_bubble), 32'h3);
    check("rd_pc_hold", 32'(a_if.pc_hold), 32'd0);
    check("rd_hold", 32'(a_if.stage_hold), 32'h0);
    tick();
    a_if.ex_redirect = 1'b0;
    a_if.ld_use_hazard = 1'b0;
    #1;
    check("rd1_valid", 32'(a_if.stage_valid), 32'h4);
    check("rd1_stall", 32'(a_if.stall_cycles), 32'd4);

    // Reset while BUSY with mc_cnt=2
    tick();
    check("pre_valid1", 32'(a_if.stage_valid), 32'h9);
    tick();
    check("pre_valid2", 32'(a_if.stage_valid), 32'h3);
    a_if.ex_multicycle = 1'b1;
    tick();
    tick();
    check("rb_busy", 32'(a_if.mul_busy), 32'd1);
    check("rb_stall", 32'(a_if.stall_cycles), 32'd6);
    reset = 1'b1;
    #1;
    check("rb_rst_busy", 32'(a_if.mul_busy), 32'd0);
    check("rb_rst_pc_hold", 32'(a_if.pc_hold), 32'd0);
    check("rb_rst_bubble", 32'(a_if.stage_bubble), 32'hf);
    tick();
    reset = 1'b0;
    #1;
    check("ra_busy", 32'(a_if.mul_busy), 32'd0);
    check("ra_valid", 32'(a_if.stage_valid), 32'h0);
    check("ra_stall", 32'(a_if.stall_cycles), 32'd0);
    a_if.ex_multicycle = 1'b0;
    tick();
    tick();
    check("ra_fill", 32'(a_if.stage_valid), 32'h3);
    a_if.ex_multicycle = 1'b1;
    #1;
    n = 0;
    while (a_if.mul_busy && n < 20) begin
      n++;
      tick();
      #1;
    end
    check("ra_busy_len", 32'(n), 32'd3);
    check("ra_done", 32'(a_if.mul_done), 32'd1);
    check("ra_stall2", 32'(a_if.stall_cycles), 32'd3);
    tick();
    a_if.ex_multicycle = 1'b0;

    // Long multiply on the narrow-counter instance
    b_if.fetch_valid = 1'b1;
    tick();
    tick();
    check("b_fill", 32'(b_if.stage_valid), 32'h3);
    b_if.ex_multicycle = 1'b1;
    #1;
    n = 0;
    while (b_if.mul_busy && n < 30) begin
      n++;
      tick();
      #1;
    end
    check("b_busy_len", 32'(n), 32'd9);
    check("b_done", 32'(b_if.mul_done), 32'd1);
    check("b_stall_sat", 32'(b_if.stall_cycles), 32'd7);
    tick();
    b_if.ex_multicycle = 1'b0;
    #1;
    check("b_stall_hold", 32'(b_if.stall_cycles), 32'd7);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
